// File: rtl/homography_pkg.sv
// ============================================================================
// Module   : homography_pkg
// Desc     : Shared state encoding, Q8.8 and RGB565 constants, MAC helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package homography_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DIV   = 3'd2,
        S_FETCH = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic signed [27:0] c_q88_one = 28'sd256;

    localparam int c_r_lsb = 11;
    localparam int c_g_lsb = 5;
    localparam int c_b_lsb = 0;

    localparam int c_img_w_default = 640;
    localparam int c_img_h_default = 480;

    function automatic logic signed [27:0] q88_sext(input logic [15:0] h);
        return {{12{h[15]}}, h};
    endfunction

    // Signed Q8.8 coefficient times an unsigned (zero-extended) pixel coordinate.
    function automatic logic signed [27:0] q88_term(input logic [15:0] h, input logic [9:0] p);
        logic signed [27:0] hs;
        logic signed [27:0] ps;
        hs = q88_sext(h);
        ps = {18'd0, p};
        return hs * ps;
    endfunction

endpackage

`default_nettype wire

// File: rtl/homography_responder_serial_divider.sv
// ============================================================================
// Module   : serial_divider
// Desc     : Unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_divider #(
    parameter int DIV_W = 28
) (
    input  logic             clk_25,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic             done
);

    localparam int c_cnt_w = $clog2(DIV_W + 1);

    logic [DIV_W-1:0]   r_rem;
    logic [DIV_W-1:0]   r_quo;
    logic [DIV_W-1:0]   r_div;
    logic [c_cnt_w-1:0] r_cnt;
    logic [DIV_W:0]     w_shift;
    logic [DIV_W:0]     w_diff;

    // r_quo starts as the dividend and shifts quotient bits in from the right.
    assign w_shift = {r_rem, r_quo[DIV_W-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_div <= divisor;
            r_cnt <= c_cnt_w'(DIV_W);
        end else if (r_cnt != '0) begin
            if (w_diff[DIV_W]) begin
                r_rem <= w_shift[DIV_W-1:0];
                r_quo <= {r_quo[DIV_W-2:0], 1'b0};
            end else begin
                r_rem <= w_diff[DIV_W-1:0];
                r_quo <= {r_quo[DIV_W-2:0], 1'b1};
            end
            r_cnt <= r_cnt - c_cnt_w'(1);
        end
    end

    assign quotient = r_quo;
    // High during the cycle in which the final quotient bit is produced.
    assign done     = (r_cnt == c_cnt_w'(1));

endmodule

`default_nettype wire

// File: rtl/homography_responder.sv
// ============================================================================
// Module   : homography_responder
// Desc     : Maps a display query through a 3x3 homography and returns the
//            RGB565 source pixel read from frame-buffer memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module homography_responder
    import homography_pkg::*;
#(
    parameter int IMG_W = c_img_w_default,
    parameter int IMG_H = c_img_h_default,
    parameter int DIV_W = 28
) (
    input  logic         clk_25,
    input  logic         rst_n,
    input  logic [9:0]   query_x,
    input  logic [9:0]   query_y,
    input  logic         start,
    input  logic [127:0] coef,
    output logic [9:0]   return_x,
    output logic [9:0]   return_y,
    output logic [4:0]   r,
    output logic [5:0]   g,
    output logic [4:0]   b,
    output logic         ready,
    output logic         busy,
    output logic         overrun,
    output logic [18:0]  mem_addr,
    output logic         mem_rd,
    input  logic [15:0]  mem_rdata,
    input  logic         mem_valid
);

    localparam logic [DIV_W-1:0] c_img_w_q = DIV_W'(IMG_W);
    localparam logic [DIV_W-1:0] c_img_h_q = DIV_W'(IMG_H);
    localparam logic [18:0]      c_img_w_a = 19'(IMG_W);

    state_t         r_state;
    logic [9:0]     r_qx;
    logic [9:0]     r_qy;
    logic [127:0]   r_coef;
    logic           r_oob;
    logic           r_fetch_issued;
    logic [9:0]     r_ret_x;
    logic [9:0]     r_ret_y;
    logic [4:0]     r_pix_r;
    logic [5:0]     r_pix_g;
    logic [4:0]     r_pix_b;
    logic           r_ready;
    logic           r_overrun;

    logic signed [27:0] w_num_u;
    logic signed [27:0] w_num_v;
    logic signed [27:0] w_w;
    logic               w_sign_fail;
    logic               w_bound_fail;
    logic [DIV_W-1:0]   w_quo_u;
    logic [DIV_W-1:0]   w_quo_v;
    logic               w_done_u;
    logic               w_done_v;
    logic [18:0]        w_addr;

    assign w_num_u = q88_term(r_coef[15:0], r_qx) + q88_term(r_coef[31:16], r_qy)
                   + q88_sext(r_coef[47:32]);
    assign w_num_v = q88_term(r_coef[63:48], r_qx) + q88_term(r_coef[79:64], r_qy)
                   + q88_sext(r_coef[95:80]);
    assign w_w     = q88_term(r_coef[111:96], r_qx) + q88_term(r_coef[127:112], r_qy)
                   + c_q88_one;

    assign w_sign_fail  = (w_w <= 28'sd0) || (w_num_u < 28'sd0) || (w_num_v < 28'sd0);
    assign w_bound_fail = (w_quo_u >= c_img_w_q) || (w_quo_v >= c_img_h_q);
    assign w_addr       = w_quo_v[18:0] * c_img_w_a + w_quo_u[18:0];

    serial_divider #(.DIV_W(DIV_W)) u_div_u (
        .clk_25   (clk_25),
        .rst_n    (rst_n),
        .load     (r_state == S_MAC),
        .dividend (DIV_W'($unsigned(w_num_u))),
        .divisor  (DIV_W'($unsigned(w_w))),
        .quotient (w_quo_u),
        .done     (w_done_u)
    );

    serial_divider #(.DIV_W(DIV_W)) u_div_v (
        .clk_25   (clk_25),
        .rst_n    (rst_n),
        .load     (r_state == S_MAC),
        .dividend (DIV_W'($unsigned(w_num_v))),
        .divisor  (DIV_W'($unsigned(w_w))),
        .quotient (w_quo_v),
        .done     (w_done_v)
    );

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_qx           <= '0;
            r_qy           <= '0;
            r_coef         <= '0;
            r_oob          <= 1'b0;
            r_fetch_issued <= 1'b0;
            r_ret_x        <= '0;
            r_ret_y        <= '0;
            r_pix_r        <= '0;
            r_pix_g        <= '0;
            r_pix_b        <= '0;
            r_ready        <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (start && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_qx    <= query_x;
                        r_qy    <= query_y;
                        r_coef  <= coef;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_oob   <= w_sign_fail;
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    r_fetch_issued <= 1'b0;
                    if (w_done_u && w_done_v) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_fetch_issued <= 1'b1;
                    if (r_oob || w_bound_fail) begin
                        r_ret_x <= r_qx;
                        r_ret_y <= r_qy;
                        r_pix_r <= '0;
                        r_pix_g <= '0;
                        r_pix_b <= '0;
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end else if (mem_valid) begin
                        r_ret_x <= r_qx;
                        r_ret_y <= r_qy;
                        r_pix_r <= mem_rdata[c_r_lsb +: 5];
                        r_pix_g <= mem_rdata[c_g_lsb +: 6];
                        r_pix_b <= mem_rdata[c_b_lsb +: 5];
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The read strobe is only for the first fetch cycle of an in-bounds request.
    assign mem_rd   = (r_state == S_FETCH) && !r_fetch_issued && !r_oob && !w_bound_fail;
    assign mem_addr = (r_state == S_FETCH) ? w_addr : '0;
    assign busy     = (r_state != S_IDLE);
    assign return_x = r_ret_x;
    assign return_y = r_ret_y;
    assign r        = r_pix_r;
    assign g        = r_pix_g;
    assign b        = r_pix_b;
    assign ready    = r_ready;
    assign overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_homography_responder.sv
// ============================================================================
// Module   : tb_homography_responder
// Desc     : Directed scoreboard bench for homography_responder.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_homography_responder;

    localparam int LAT_IN  = 32;
    localparam int LAT_OOB = 31;

    logic         clk_25 = 1'b0;
    logic         rst_n;
    logic [9:0]   query_x;
    logic [9:0]   query_y;
    logic         start;
    logic [127:0] coef;
    logic [9:0]   return_x;
    logic [9:0]   return_y;
    logic [4:0]   r;
    logic [5:0]   g;
    logic [4:0]   b;
    logic         ready;
    logic         busy;
    logic         overrun;
    logic [18:0]  mem_addr;
    logic         mem_rd;
    logic [15:0]  mem_rdata;
    logic         mem_valid;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [18:0] addr;
        logic [15:0] data;
    } mem_t;

    exp_t sb_q[$];
    mem_t mem_q[$];
    exp_t e_pop;
    mem_t m_pop;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_cnt = 0;
    logic        mem_pending = 1'b0;
    logic [15:0] mem_pdata = '0;

    homography_responder dut (
        .clk_25    (clk_25),
        .rst_n     (rst_n),
        .query_x   (query_x),
        .query_y   (query_y),
        .start     (start),
        .coef      (coef),
        .return_x  (return_x),
        .return_y  (return_y),
        .r         (r),
        .g         (g),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .overrun   (overrun),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    always #20 clk_25 = ~clk_25;
    always @(posedge clk_25) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] mk(input logic [15:0] h0, h1, h2, h3, h4, h5, h6, h7);
        return {h7, h6, h5, h4, h3, h2, h1, h0};
    endfunction

    // Scoreboard monitor: every ready pulse is matched against the oldest request.
    always @(negedge clk_25) begin
        if (ready) begin
            ready_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e_pop = sb_q.pop_front();
                chk("return_x", 32'(return_x), 32'(e_pop.x));
                chk("return_y", 32'(return_y), 32'(e_pop.y));
                chk("pix_r", 32'(r), 32'(e_pop.r));
                chk("pix_g", 32'(g), 32'(e_pop.g));
                chk("pix_b", 32'(b), 32'(e_pop.b));
                chk("ready_cycle", 32'(cyc), 32'(e_pop.cyc));
            end
        end
    end

    // One-cycle memory model: mem_valid follows mem_rd by one cycle.
    initial begin
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk_25);
            mem_valid = 1'b0;
            if (mem_pending) begin
                mem_valid   = 1'b1;
                mem_rdata   = mem_pdata;
                mem_pending = 1'b0;
            end
            if (mem_rd) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_rd: actual=1 required=0 addr=%0d (cycle %0d)", mem_addr, cyc);
                end else begin
                    m_pop = mem_q.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(m_pop.addr));
                    mem_pdata   = m_pop.data;
                    mem_pending = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [9:0] x, input logic [9:0] y, input logic [127:0] c,
                         input bit oob, input logic [18:0] addr, input logic [15:0] data,
                         input bit track);
        exp_t e;
        mem_t m;
        @(negedge clk_25);
        query_x = x;
        query_y = y;
        coef    = c;
        start   = 1'b1;
        e.x   = x;
        e.y   = y;
        e.cyc = cyc + (oob ? LAT_OOB : LAT_IN);
        if (oob) begin
            e.r = '0;
            e.g = '0;
            e.b = '0;
        end else begin
            e.r    = data[15:11];
            e.g    = data[10:5];
            e.b    = data[4:0];
            m.addr = addr;
            m.data = data;
            mem_q.push_back(m);
        end
        if (track) sb_q.push_back(e);
        @(negedge clk_25);
        start = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk_25);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual ready=0 required 1 within 100 cycles", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

    logic [127:0] c_id;
    logic [9:0]   bx [4];
    logic [9:0]   by [4];
    logic [18:0]  ba [4];
    logic [15:0]  bd [4];
    int           rc0;
    int           n;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        query_x = '0;
        query_y = '0;
        coef    = '0;
        c_id    = mk(16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0);
        repeat (3) @(negedge clk_25);

        chk("rst_ready", 32'(ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_return", 32'({return_x, return_y}), 0);
        chk("rst_rgb", 32'({r, g, b}), 0);
        rst_n = 1'b1;

        // Identity mapping
        issue(10'd100, 10'd50, c_id, 1'b0, 19'd32100, 16'hF800, 1'b1);
        chk("busy_during_op", 32'(busy), 1);
        wait_ready("identity");

        // Scale by two
        issue(10'd200, 10'd100, mk(16'h0200, 0, 0, 0, 16'h0200, 0, 0, 0), 1'b0,
              19'd128400, 16'h07E0, 1'b1);
        wait_ready("scale2x");

        // u lands exactly on IMG_W
        issue(10'd639, 10'd479, mk(16'h0100, 0, 16'h0100, 0, 16'h0100, 0, 0, 0), 1'b1,
              '0, '0, 1'b1);
        wait_ready("oob_u");

        // Negative w
        issue(10'd5, 10'd5, mk(16'h0100, 0, 0, 0, 16'h0100, 0, 16'hFF00, 0), 1'b1,
              '0, '0, 1'b1);
        wait_ready("oob_w");

        // Back-to-back: each start lands one cycle after the previous ready
        bx = '{10'd1, 10'd3, 10'd639, 10'd0};
        by = '{10'd2, 10'd4, 10'd479, 10'd0};
        ba = '{19'd1281, 19'd2563, 19'd307199, 19'd0};
        bd = '{16'h001F, 16'hA5A5, 16'hFFFF, 16'h1234};
        for (int i = 0; i < 4; i++) begin
            issue(bx[i], by[i], c_id, 1'b0, ba[i], bd[i], 1'b1);
            wait_ready("back_to_back");
        end
        chk("b2b_overrun", 32'(overrun), 0);

        // start while busy is dropped and flags overrun
        issue(10'd10, 10'd20, c_id, 1'b0, 19'd12810, 16'h8410, 1'b1);
        repeat (5) @(negedge clk_25);
        query_x = 10'd7;
        start   = 1'b1;
        @(negedge clk_25);
        start   = 1'b0;
        chk("overrun_set", 32'(overrun), 1);
        wait_ready("overrun_req");
        @(negedge clk_25);
        chk("overrun_sticky", 32'(overrun), 1);
        chk("idle_after_resp", 32'(busy), 0);

        // Reset while waiting on memory
        issue(10'd2, 10'd2, c_id, 1'b0, 19'd1282, 16'hFFFF, 1'b0);
        n = 0;
        while (!mem_rd && n < 100) begin
            @(negedge clk_25);
            n++;
        end
        chk("mem_rd_before_reset", 32'(mem_rd), 1);
        @(negedge clk_25);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_mem_rd", 32'(mem_rd), 0);
        chk("midrst_ready", 32'(ready), 0);
        chk("midrst_overrun", 32'(overrun), 0);
        chk("midrst_return", 32'({return_x, return_y}), 0);
        chk("midrst_rgb", 32'({r, g, b}), 0);
        rc0 = ready_cnt;
        repeat (2) @(negedge clk_25);
        rst_n = 1'b1;
        @(negedge clk_25);
        mem_pdata   = 16'hFFFF;
        mem_pending = 1'b1;
        repeat (10) @(negedge clk_25);
        chk("late_valid_no_ready", 32'(ready_cnt - rc0), 0);
        chk("late_valid_idle", 32'(busy), 0);
        chk("mem_queue_drained", 32'(mem_q.size()), 0);

        // Recovery after reset
        issue(10'd100, 10'd50, c_id, 1'b0, 19'd32100, 16'h001F, 1'b1);
        wait_ready("recovery");
        @(negedge clk_25);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/homography_responder.md
# homography_responder

Responder end of the query/return pixel handshake driven by the display sync controller. It accepts a display coordinate (query_x, query_y) on a start pulse and maps it through a programmable 3x3 homography, with h8 fixed at 1.0, to a source coordinate in the CCD frame buffer. It fetches that pixel from frame-buffer memory and answers with a one-cycle ready pulse carrying the echoed coordinate and the RGB565 pixel. It sits between the sync controller and the SDRAM/SRAM frame-buffer read port.

## Interface
Parameters:
- IMG_W, 640, source frame width in pixels
- IMG_H, 480, source frame height in pixels
- DIV_W, 28, divider operand width; one quotient bit per cycle

Ports:
- clk_25  input  1  pixel clock; single clock domain
- rst_n  input  1  reset; asynchronous, active-low
- query_x  input  10  display x of request
- query_y  input  10  display y of request
- start  input  1  one-cycle request strobe
- coef  input  128  h0..h7, signed Q8.8, h0 in [15:0] through h7 in [127:112]; sampled with start
- return_x  output  10  echoed query_x
- return_y  output  10  echoed query_y
- r  output  5  pixel red
- g  output  6  pixel green
- b  output  5  pixel blue
- ready  output  1  one-cycle response strobe
- busy  output  1  high in every state except S_IDLE
- overrun  output  1  sticky; set when start arrives while busy
- mem_addr  output  19  frame-buffer word address
- mem_rd  output  1  one-cycle read strobe
- mem_rdata  input  16  RGB565 word {r[15:11], g[10:5], b[4:0]}
- mem_valid  input  1  mem_rdata valid; one cycle per mem_rd

## Operation
- Mapping: num_u = h0*x + h1*y + h2; num_v = h3*x + h4*y + h5; w = h6*x + h7*y + 256.
  - All terms are 28-bit signed Q8.8; x and y are zero-extended.
  - u = num_u / w and v = num_v / w, unsigned truncating quotients.
- Out of bounds (OOB) when any of the following holds. An OOB response returns r=g=b=0 and issues no memory read.
  - w <= 0
  - num_u < 0 or num_v < 0
  - u >= IMG_W or v >= IMG_H
- mem_addr = v*IMG_W + u, 19 bits.
- FSM states and transitions:
  - S_IDLE: on start, latch query_x, query_y and coef; go to S_MAC.
  - S_MAC: register num_u, num_v and w; launch both dividers; go to S_DIV. If the sign test already fails, set the OOB flag; the dividers still run.
  - S_DIV: DIV_W cycles; go to S_FETCH.
  - S_FETCH: if OOB, go straight to S_RESP. Otherwise assert mem_rd for its first cycle only, then wait for mem_valid and capture mem_rdata.
  - S_RESP: ready=1 for one cycle; go to S_IDLE.
- Outputs return_x, return_y, r, g, b update only on entry to S_RESP and hold until the next response.
- start outside S_IDLE is ignored and sets overrun, which clears only on reset.
- mem_valid outside S_FETCH is ignored.

## Timing
- Reset values: all outputs 0; state S_IDLE; internal coefficient and coordinate registers 0.
- Take start high in cycle k. Then:
  - S_MAC is cycle k+1.
  - S_DIV is cycles k+2 .. k+1+DIV_W.
  - S_FETCH begins at cycle k+2+DIV_W, with mem_rd high in that cycle.
- In-bounds response: mem_valid in cycle m gives ready in m+1. With a 1-cycle memory, ready is at k+DIV_W+4 (k+32 at default).
- OOB response: ready at k+DIV_W+3.
- Back-to-back operation: start may arrive in the cycle immediately after ready (the FSM is in S_IDLE by then) and must be accepted.
- Reset mid-operation: the FSM returns to S_IDLE immediately, mem_rd drops, and no ready is produced. A late mem_valid after reset is ignored.
- start and ready are never high in the same cycle.

## Structure
- Shared package homography_pkg:
  - state encoding for S_IDLE, S_MAC, S_DIV, S_FETCH, S_RESP
  - Q8.8 ONE = 256
  - RGB565 field positions
  - default IMG_W and IMG_H
- Sub-module serial_divider:
  - unsigned restoring divider, DIV_W bits, one bit per cycle
  - ports: load, dividend, divisor, quotient, done
  - instantiated twice, for u and v, both running concurrently

## Test plan
- Identity mapping (h0=h4=0x0100, rest 0), query (100,50) -> mem_addr=32100; mem_rdata=0xF800 one cycle later -> ready at k+32 with r=31, g=0, b=0, return=(100,50).
- Scale 2x (h0=h4=0x0200), query (200,100) -> u=400, v=200, mem_addr=128400.
- Out of bounds:
  - identity coefficients, query (639,479) with h2=0x0100 (u=640) -> no mem_rd, ready at k+31, rgb=0.
  - h6=0xFF00 (w<=0 for x>=1), query (5,5) -> same OOB response.
- Back-to-back: start one cycle after each ready, 4 queries -> 4 ready pulses, each with matching return_x/y; overrun stays 0.
- start pulsed during S_DIV -> ignored; overrun=1 sticky; the original request still completes.
- rst_n low during S_FETCH after mem_rd -> outputs 0, busy=0; mem_valid then pulsed -> no ready.
